// File: rtl/time_pkg.sv
// Shared definitions for the time-set controller: editing modes, field limits,
// key indices and wrap-around step helpers for the hours/minutes fields.
package time_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_SET_H = 2'd1,
      MODE_SET_M = 2'd2
   } mode_t;

   localparam logic [4:0] MAX_HOURS   = 5'd23;
   localparam logic [5:0] MAX_MINUTES = 6'd59;

   localparam int KEY_MODE   = 0;
   localparam int KEY_INC    = 1;
   localparam int KEY_DEC    = 2;
   localparam int KEY_CANCEL = 3;

   // One step of the hours field, wrapping 23 <-> 0.
   function automatic logic [4:0] hours_step(input logic [4:0] h, input logic up);
      if (up) return (h == MAX_HOURS) ? 5'd0 : h + 5'd1;
      else    return (h == 5'd0) ? MAX_HOURS : h - 5'd1;
   endfunction

   // One step of the minutes field, wrapping 59 <-> 0.
   function automatic logic [5:0] minutes_step(input logic [5:0] m, input logic up);
      if (up) return (m == MAX_MINUTES) ? 6'd0 : m + 6'd1;
      else    return (m == 6'd0) ? MAX_MINUTES : m - 6'd1;
   endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Signal bundle between the time-set controller and its surroundings:
// raw keys and live time in, shadow time, load strobe and display flags out.
interface time_set_ctrl_if;
   logic [3:0] key_n;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes;
   logic [4:0] set_hours;
   logic [5:0] set_minutes;
   logic       load;
   logic       hold_run;
   logic [1:0] mode;
   logic       blink_on;
   logic       hours_visible;
   logic       minutes_visible;

   modport slave (
      input  key_n, cur_hours, cur_minutes,
      output set_hours, set_minutes, load, hold_run, mode,
             blink_on, hours_visible, minutes_visible
   );

   modport master (
      output key_n, cur_hours, cur_minutes,
      input  set_hours, set_minutes, load, hold_run, mode,
             blink_on, hours_visible, minutes_visible
   );
endinterface

// File: rtl/time_set_ctrl_key_debounce.sv
// Debouncer for one active-low push-button: 2-FF synchronizer, stability
// counter, and a one-cycle press pulse on an accepted 1->0 transition.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_raw,
   output logic stable,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cnt;

   // Bring the asynchronous key into the clock domain (idle level is released).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= key_raw;
         sync_b <= sync_a;
      end
   end

   // Accept a new level once it has differed from the stable one long enough.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         stable <= 1'b1;
         press  <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_b == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt    <= '0;
            stable <= sync_b;
            press  <= stable;   // only a released->pressed change is an event
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: debounces four keys and runs the RUN/SET_H/SET_M editor
// for the shadow hh:mm, issuing a one-cycle load strobe on confirmation.
// Also produces the blink phase and per-field visibility flags.
// Optional build macro TIME_SET_AUTOREPEAT_EN adds auto-repeat of held inc/dec.
module time_set_ctrl
   import time_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = 500_000,
   parameter int BLINK_HALF_CYCLES   = 25_000_000,
   parameter int REPEAT_DELAY_CYCLES = 25_000_000,
   parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
   input  logic           clk,
   input  logic           reset_n,
   time_set_ctrl_if.slave bus
);

   localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

   logic [1:0]    rst_sync;
   logic          rst_int_n;
   logic [3:0]    key_stable;
   logic [3:0]    key_press;
   mode_t         mode_q;
   mode_t         mode_nx;
   logic [4:0]    hours_q;
   logic [5:0]    minutes_q;
   logic          load_q;
   logic          blink_q;
   logic [BW-1:0] blink_cnt;
   logic          capture;
   logic          load_nx;
   logic          step_up;
   logic          step_dn;
   logic          blink_restart;
   logic          inc_evt;
   logic          dec_evt;
   logic          rpt_inc;
   logic          rpt_dec;

   // Reset asserts immediately and releases synchronously to the clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
         .clk     (clk),
         .reset_n (rst_int_n),
         .key_raw (bus.key_n[i]),
         .stable  (key_stable[i]),
         .press   (key_press[i])
      );
   end

`ifdef TIME_SET_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
   localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

   logic [RW-1:0] rpt_cnt;
   logic          rpt_armed;
   logic          held_inc;
   logic          held_dec;
   logic          rpt_hold;
   logic          rpt_fire;

   assign held_inc = ~key_stable[KEY_INC];
   assign held_dec = ~key_stable[KEY_DEC];
   // A mode/cancel event means the state is about to change, so the hold restarts.
   assign rpt_hold = (mode_q != MODE_RUN) && (held_inc ^ held_dec) &&
                     !key_press[KEY_MODE] && !key_press[KEY_CANCEL];
   assign rpt_fire = rpt_hold && (rpt_armed ? (rpt_cnt == RW'(REPEAT_RATE_CYCLES - 1))
                                            : (rpt_cnt == RW'(REPEAT_DELAY_CYCLES - 1)));
   assign rpt_inc  = rpt_fire & held_inc;
   assign rpt_dec  = rpt_fire & held_dec;

   // Hold timer: first step after the delay, then one step per rate period.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else if (!rpt_hold) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else if (rpt_fire) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b1;
      end else begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end
`else
   localparam int unused_rpt_cfg = REPEAT_DELAY_CYCLES + REPEAT_RATE_CYCLES;
   logic unused_stable;
   assign unused_stable = &key_stable;
   assign rpt_inc = 1'b0;
   assign rpt_dec = 1'b0;
`endif

   assign inc_evt = key_press[KEY_INC] | rpt_inc;
   assign dec_evt = key_press[KEY_DEC] | rpt_dec;

   // Editor state register.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) mode_q <= MODE_RUN;
      else            mode_q <= mode_nx;
   end

   // Next state and edit actions; cancel beats mode, both beat inc/dec.
   always_comb begin
      mode_nx       = mode_q;
      capture       = 1'b0;
      load_nx       = 1'b0;
      step_up       = 1'b0;
      step_dn       = 1'b0;
      blink_restart = 1'b0;
      unique case (mode_q)
         MODE_RUN: begin
            if (key_press[KEY_MODE]) begin
               mode_nx       = MODE_SET_H;
               capture       = 1'b1;
               blink_restart = 1'b1;
            end
         end
         MODE_SET_H, MODE_SET_M: begin
            if (key_press[KEY_CANCEL]) begin
               mode_nx = MODE_RUN;
            end else if (key_press[KEY_MODE]) begin
               if (mode_q == MODE_SET_H) begin
                  mode_nx       = MODE_SET_M;
                  blink_restart = 1'b1;
               end else begin
                  mode_nx = MODE_RUN;
                  load_nx = 1'b1;
               end
            end else if (inc_evt && !dec_evt) begin
               step_up       = 1'b1;
               blink_restart = 1'b1;
            end else if (dec_evt && !inc_evt) begin
               step_dn       = 1'b1;
               blink_restart = 1'b1;
            end
         end
         default: mode_nx = MODE_RUN;
      endcase
   end

   // Shadow time and load strobe: capture live time, or step the active field.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         hours_q   <= '0;
         minutes_q <= '0;
         load_q    <= 1'b0;
      end else begin
         load_q <= load_nx;
         if (capture) begin
            hours_q   <= bus.cur_hours;
            minutes_q <= bus.cur_minutes;
         end else if (step_up || step_dn) begin
            if (mode_q == MODE_SET_H) hours_q   <= hours_step(hours_q, step_up);
            else                      minutes_q <= minutes_step(minutes_q, step_up);
         end
      end
   end

   // Blink phase: free-running half-period toggle, restarted visible on edits.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         blink_cnt <= '0;
         blink_q   <= 1'b1;
      end else if (blink_restart) begin
         blink_cnt <= '0;
         blink_q   <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_HALF_CYCLES - 1)) begin
         blink_cnt <= '0;
         blink_q   <= ~blink_q;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign bus.set_hours       = hours_q;
   assign bus.set_minutes     = minutes_q;
   assign bus.load            = load_q;
   assign bus.hold_run        = (mode_q != MODE_RUN);
   assign bus.mode            = mode_q;
   assign bus.blink_on        = blink_q;
   assign bus.hours_visible   = (mode_q != MODE_SET_H) | blink_q;
   assign bus.minutes_visible = (mode_q != MODE_SET_M) | blink_q;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Upstream stage of the hh:mm:ss timekeeper. Debounces the four raw active-low push-buttons and runs a RUN / SET_H / SET_M state machine that edits a shadow hours/minutes pair. On exit it emits a one-cycle load strobe that the timekeeper uses to take the new time. It also generates the 0.5 s blink phase and per-field visibility flags for the HEX/LEDG display logic.

Parameters:
- DEBOUNCE_CYCLES, 500_000: input must be stable this many cycles (10 ms at 50 MHz) before it is accepted.
- BLINK_HALF_CYCLES, 25_000_000: blink half-period (0.5 s).
- REPEAT_DELAY_CYCLES, 25_000_000: hold time before the first auto-repeat step (used only with the optional feature).
- REPEAT_RATE_CYCLES, 10_000_000: period between auto-repeat steps (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- key_n  in  4  raw KEY inputs, active-low, asynchronous. [0]=mode, [1]=inc, [2]=dec, [3]=cancel.
- cur_hours  in  5  live hours from the timekeeper, 0..23
- cur_minutes  in  6  live minutes from the timekeeper, 0..59
- set_hours  out  5  shadow hours, 0..23
- set_minutes  out  6  shadow minutes, 0..59
- load  out  1  one-cycle strobe; timekeeper loads set_* and clears seconds
- hold_run  out  1  high in SET_H/SET_M; timekeeper freezes
- mode  out  2  0=RUN, 1=SET_H, 2=SET_M
- blink_on  out  1  blink phase
- hours_visible  out  1  low only in SET_H while blink_on=0
- minutes_visible  out  1  low only in SET_M while blink_on=0

Behaviour:
- Reset (async assert, sync deassert internal use) sets: mode=RUN, set_*=0, load=0, hold_run=0, blink_on=1, both visibles=1, debouncers' stable state=released (1), all counters=0.
- Reset mid-edit returns to RUN with no load pulse.
- Debounce path, per key:
  - 2-FF synchronizer.
  - A counter clears on any mismatch between the synchronized input and the stable state; when it reaches DEBOUNCE_CYCLES-1 the stable state takes the input.
  - A press event is a one-cycle pulse on a stable 1->0 transition. Release produces no event.
- FSM, evaluated on press events:
  - RUN + mode: capture cur_hours/cur_minutes into set_*, go to SET_H; hold_run=1 from the next cycle.
  - SET_H + mode: go to SET_M.
  - SET_M + mode: go to RUN; load=1 for exactly the cycle after the event; hold_run drops in that same cycle; set_* unchanged.
  - SET_H/SET_M + cancel: go to RUN, no load.
  - In RUN, inc, dec and cancel are ignored.
- Edit arithmetic (applies to the active field only):
  - inc: hours 23->0, minutes 59->0, otherwise +1.
  - dec: hours 0->23, minutes 0->59, otherwise -1.
  - Results are always in range; no intermediate overflow.
- Simultaneous events in one cycle:
  - mode or cancel wins over inc/dec, which are dropped.
  - mode and cancel together: cancel wins.
  - inc and dec together: both dropped.
- Blink:
  - Free-running counter; blink_on toggles when it reaches BLINK_HALF_CYCLES-1, then the counter wraps to 0.
  - Entering SET_H or SET_M, or any applied inc/dec, sets the counter to 0 and blink_on to 1, so the edited field is visible immediately.
- Visibility:
  - hours_visible = (mode!=SET_H) | blink_on.
  - minutes_visible = (mode!=SET_M) | blink_on.
  - In RUN, both visibles are 1 regardless of blink_on.
- Latency: raw key edge -> FSM action = 2 sync + DEBOUNCE_CYCLES + 1 cycles.

Optional Feature:
- TIME_SET_AUTOREPEAT_EN defined:
  - While inc or dec is held in a SET state, one extra step is applied after REPEAT_DELAY_CYCLES, then one every REPEAT_RATE_CYCLES.
  - The repeat counter clears on release, on a state change, or when both keys are held.
- Not defined: exactly one step per press; repeat counters and their parameters are unused and not synthesized.

Decomposition:
- Shared package time_pkg holds:
  - mode constants MODE_RUN=2'd0, MODE_SET_H=2'd1, MODE_SET_M=2'd2
  - MAX_HOURS=23, MAX_MINUTES=59
  - key index constants KEY_MODE=0, KEY_INC=1, KEY_DEC=2, KEY_CANCEL=3
- One sub-module, key_debounce (synchronizer + counter + press pulse, parameter DEBOUNCE_CYCLES), instantiated 4 times.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=8, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=5):
- Reset with key_n=4'hF -> mode=0, set_*=0, load=0, hold_run=0, blink_on=1; a 2-cycle glitch on key_n[0] produces no mode change.
- cur=23:55; press mode; press inc x1 (hours 23->0); press mode; press dec x56 (minutes 55->59) -> set=00:59; press mode -> single load pulse with set_hours=0, set_minutes=59; mode=0.
- Enter SET_H, press inc 3 times, press cancel -> mode=0, no load ever asserted, hold_run=0.
- In SET_M, press inc and dec in the same cycle -> set_minutes unchanged; press mode+inc in the same cycle -> mode advances, value unchanged.
- In SET_H, observe minutes_visible=1 and hours_visible toggling every 8 cycles; press inc at phase 0 -> blink_on forced to 1, counter restarted.
- With TIME_SET_AUTOREPEAT_EN: hold inc for 40 cycles after acceptance -> 1 + 1 + floor((40-20)/5)=6 total steps; without the macro -> exactly 1 step.
